// File: rtl/pipe_datapath_fwd.sv
// Parametrised 5-stage pipelined integer datapath with forwarding, load-use
// interlock and jump flush; control signals come from an external decoder.
module pipe_datapath_fwd #(
    parameter int    XLEN      = 32,
    parameter int    NREGS     = 32,
    parameter int    IMEM_AW   = 7,
    parameter int    DMEM_AW   = 7,
    parameter string IMEM_FILE = "instruction_memory.dat",
    parameter string DMEM_FILE = "data_memory.dat"
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [1:0]         MemToReg,
    input  logic               RegWrite,
    input  logic               PCSrc,
    input  logic [3:0]         ALUOp,
    input  logic [1:0]         ALUSrc,
    output logic [7:0]         Op,
    output logic [IMEM_AW-1:0] pc,
    output logic               stall,
    output logic               flush,
    input  logic [4:0]         dbg_raddr,
    output logic [XLEN-1:0]    dbg_rdata
);
    localparam int RIDX = $clog2(NREGS);
    typedef logic [RIDX-1:0] ridx_t;
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] memtoreg;
        logic [3:0] aluop;
        logic [1:0] alusrc;
    } ctl_t;

    logic [7:0]      imem [2**IMEM_AW];
    logic [7:0]      dmem [2**DMEM_AW];
    logic [XLEN-1:0] rf   [NREGS];

    logic [IMEM_AW-1:0] pc_q, pc_d, pc_plus4;
    logic [31:0]        fetch_instr;
    logic               ifid_valid_q, ifid_valid_d;
    logic [31:0]        ifid_instr_q, ifid_instr_d;
    logic [IMEM_AW-1:0] ifid_pc4_q, ifid_pc4_d;

    ctl_t               idex_ctl_q, idex_ctl_d, id_ctl;
    ridx_t              idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d, idex_rd_q, idex_rd_d;
    logic [XLEN-1:0]    idex_a_q, idex_a_d, idex_b_q, idex_b_d;
    logic [XLEN-1:0]    idex_imm_q, idex_imm_d, idex_shamt_q, idex_shamt_d;
    logic [IMEM_AW-1:0] idex_pc4_q, idex_pc4_d;

    logic               exmem_regwrite_q, exmem_regwrite_d, exmem_memread_q, exmem_memread_d;
    logic               exmem_memwrite_q, exmem_memwrite_d;
    logic [1:0]         exmem_memtoreg_q, exmem_memtoreg_d;
    ridx_t              exmem_rd_q, exmem_rd_d;
    logic [XLEN-1:0]    exmem_alu_q, exmem_alu_d, exmem_sd_q, exmem_sd_d;
    logic [IMEM_AW-1:0] exmem_pc4_q, exmem_pc4_d;

    logic               memwb_regwrite_q, memwb_regwrite_d;
    logic [1:0]         memwb_memtoreg_q, memwb_memtoreg_d;
    ridx_t              memwb_rd_q, memwb_rd_d;
    logic [XLEN-1:0]    memwb_alu_q, memwb_alu_d, memwb_ld_q, memwb_ld_d;
    logic [IMEM_AW-1:0] memwb_pc4_q, memwb_pc4_d;

    ridx_t              id_rs1, id_rs2, id_rd, dbg_idx;
    logic [XLEN-1:0]    id_a, id_b, wb_data, fwd_a, fwd_b, alu_b, alu_res, sh, mem_rdata;
    logic [IMEM_AW-1:0] id_target;
    logic               mw_fwd, wb_we;
    logic [DMEM_AW-1:0] ma0, ma1, ma2, ma3;
    logic [31:0]        ld_word, st_word;

    // Fetch and decode
    always_comb begin
        pc_plus4    = pc_q + IMEM_AW'(4);
        fetch_instr = {imem[pc_q], imem[pc_q + IMEM_AW'(1)],
                       imem[pc_q + IMEM_AW'(2)], imem[pc_q + IMEM_AW'(3)]};
        id_rd     = ifid_instr_q[27 +: RIDX];
        id_rs1    = ifid_instr_q[22 +: RIDX];
        id_rs2    = ifid_instr_q[17 +: RIDX];
        id_target = ifid_instr_q[8 +: IMEM_AW];
        Op        = ifid_valid_q ? ifid_instr_q[7:0] : 8'h00;
        id_ctl    = ifid_valid_q ? ctl_t'{MemRead, MemWrite, RegWrite, MemToReg, ALUOp, ALUSrc} : '0;
        dbg_idx   = dbg_raddr[RIDX-1:0];
        pc        = pc_q;
    end

    // Register file reads see a same-cycle WB write; R0 is forced to zero last
    always_comb begin
        mw_fwd = memwb_regwrite_q && (memwb_rd_q != '0);
        wb_we  = mw_fwd && !reset;
        case (memwb_memtoreg_q)
            2'b00:   wb_data = memwb_ld_q;
            2'b10:   wb_data = XLEN'(memwb_pc4_q);
            default: wb_data = memwb_alu_q;
        endcase
        id_a      = (wb_we && memwb_rd_q == id_rs1) ? wb_data : rf[id_rs1];
        id_b      = (wb_we && memwb_rd_q == id_rs2) ? wb_data : rf[id_rs2];
        dbg_rdata = (wb_we && memwb_rd_q == dbg_idx) ? wb_data : rf[dbg_idx];
        if (id_rs1 == '0) id_a = '0;
        if (id_rs2 == '0) id_b = '0;
        if (dbg_idx == '0) dbg_rdata = '0;
    end

    // Hazard control: a load-use stall suppresses any jump in ID this cycle
    always_comb begin
        stall = idex_ctl_q.memread && (idex_rd_q != '0) &&
                ((idex_rd_q == id_rs1) || (idex_rd_q == id_rs2));
        flush = ifid_valid_q && PCSrc && !stall;
        pc_d         = pc_plus4;
        ifid_valid_d = 1'b1;
        ifid_instr_d = fetch_instr;
        ifid_pc4_d   = pc_plus4;
        if (stall) begin
            pc_d         = pc_q;
            ifid_valid_d = ifid_valid_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
        end else if (flush) begin
            pc_d         = id_target;
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            ifid_pc4_d   = ifid_pc4_q;
        end
        idex_ctl_d   = stall ? ctl_t'('0) : id_ctl;
        idex_rs1_d   = id_rs1;
        idex_rs2_d   = id_rs2;
        idex_rd_d    = id_rd;
        idex_a_d     = id_a;
        idex_b_d     = id_b;
        idex_imm_d   = XLEN'($signed(ifid_instr_q[16:8]));
        idex_shamt_d = XLEN'(ifid_instr_q[16:8]);
        idex_pc4_d   = ifid_pc4_q;
    end

    // Execute with forwarding; store data is the forwarded rs2, not the ALU result
    always_comb begin
        fwd_a = idex_a_q;
        if (exmem_regwrite_q && exmem_rd_q != '0 && exmem_rd_q == idex_rs1_q) fwd_a = exmem_alu_q;
        else if (mw_fwd && memwb_rd_q == idex_rs1_q) fwd_a = wb_data;
        fwd_b = idex_b_q;
        if (exmem_regwrite_q && exmem_rd_q != '0 && exmem_rd_q == idex_rs2_q) fwd_b = exmem_alu_q;
        else if (mw_fwd && memwb_rd_q == idex_rs2_q) fwd_b = wb_data;
        case (idex_ctl_q.alusrc)
            2'b01:   alu_b = idex_imm_q;
            2'b10:   alu_b = idex_shamt_q;
            default: alu_b = fwd_b;
        endcase
        sh = alu_b % XLEN'(XLEN);
        case (idex_ctl_q.aluop)
            4'd1:    alu_res = fwd_a - alu_b;
            4'd2:    alu_res = fwd_a * alu_b;
            4'd3:    alu_res = fwd_a ^ alu_b;
            4'd4:    alu_res = fwd_a | alu_b;
            4'd5:    alu_res = fwd_a & alu_b;
            4'd6:    alu_res = fwd_a << sh;
            4'd7:    alu_res = $signed(fwd_a) >>> sh;
            4'd8:    alu_res = fwd_a >> sh;
            default: alu_res = fwd_a + alu_b;
        endcase
        exmem_regwrite_d = idex_ctl_q.regwrite;
        exmem_memread_d  = idex_ctl_q.memread;
        exmem_memwrite_d = idex_ctl_q.memwrite;
        exmem_memtoreg_d = idex_ctl_q.memtoreg;
        exmem_rd_d       = idex_rd_q;
        exmem_alu_d      = alu_res;
        exmem_sd_d       = fwd_b;
        exmem_pc4_d      = idex_pc4_q;
    end

    // Memory stage: big-endian word, byte addresses wrap around the data memory
    always_comb begin
        ma0       = exmem_alu_q[DMEM_AW-1:0];
        ma1       = ma0 + DMEM_AW'(1);
        ma2       = ma0 + DMEM_AW'(2);
        ma3       = ma0 + DMEM_AW'(3);
        ld_word   = {dmem[ma0], dmem[ma1], dmem[ma2], dmem[ma3]};
        st_word   = 32'(exmem_sd_q);
        mem_rdata = exmem_memread_q ? XLEN'(ld_word) : '0;
        memwb_regwrite_d = exmem_regwrite_q;
        memwb_memtoreg_d = exmem_memtoreg_q;
        memwb_rd_d       = exmem_rd_q;
        memwb_alu_d      = exmem_alu_q;
        memwb_ld_d       = mem_rdata;
        memwb_pc4_d      = exmem_pc4_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= '0;
            ifid_valid_q     <= 1'b0;
            ifid_instr_q     <= '0;
            idex_ctl_q       <= '0;
            exmem_regwrite_q <= 1'b0;
            exmem_memread_q  <= 1'b0;
            exmem_memwrite_q <= 1'b0;
            memwb_regwrite_q <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            ifid_valid_q     <= ifid_valid_d;
            ifid_instr_q     <= ifid_instr_d;
            idex_ctl_q       <= idex_ctl_d;
            exmem_regwrite_q <= exmem_regwrite_d;
            exmem_memread_q  <= exmem_memread_d;
            exmem_memwrite_q <= exmem_memwrite_d;
            memwb_regwrite_q <= memwb_regwrite_d;
        end
        ifid_pc4_q       <= ifid_pc4_d;
        idex_rs1_q       <= idex_rs1_d;
        idex_rs2_q       <= idex_rs2_d;
        idex_rd_q        <= idex_rd_d;
        idex_a_q         <= idex_a_d;
        idex_b_q         <= idex_b_d;
        idex_imm_q       <= idex_imm_d;
        idex_shamt_q     <= idex_shamt_d;
        idex_pc4_q       <= idex_pc4_d;
        exmem_memtoreg_q <= exmem_memtoreg_d;
        exmem_rd_q       <= exmem_rd_d;
        exmem_alu_q      <= exmem_alu_d;
        exmem_sd_q       <= exmem_sd_d;
        exmem_pc4_q      <= exmem_pc4_d;
        memwb_memtoreg_q <= memwb_memtoreg_d;
        memwb_rd_q       <= memwb_rd_d;
        memwb_alu_q      <= memwb_alu_d;
        memwb_ld_q       <= memwb_ld_d;
        memwb_pc4_q      <= memwb_pc4_d;
    end

    always_ff @(posedge clk) begin
        if (wb_we) rf[memwb_rd_q] <= wb_data;
    end

    always_ff @(posedge clk) begin
        if (!reset && exmem_memwrite_q) begin
            dmem[ma0] <= st_word[31:24];
            dmem[ma1] <= st_word[23:16];
            dmem[ma2] <= st_word[15:8];
            dmem[ma3] <= st_word[7:0];
        end
    end
endmodule

// File: tb/tb_pipe_datapath_fwd.sv
// Directed bench for pipe_datapath_fwd: small programs loaded into instruction
// memory, a stand-in control unit, and scoreboarded pc/stall/flush/register checks.
module tb_pipe_datapath_fwd;
    localparam int XLEN = 32;
    localparam int IMEM_AW = 7;
    localparam int DMEM_AW = 7;

    localparam logic [7:0] OP_ADD = 8'h01, OP_ADDI = 8'h02, OP_LW = 8'h03, OP_SW = 8'h04;
    localparam logic [7:0] OP_J = 8'h05, OP_SUB = 8'h06, OP_MUL = 8'h07, OP_XOR = 8'h08;
    localparam logic [7:0] OP_OR = 8'h09, OP_AND = 8'h0A, OP_SLLI = 8'h0B, OP_SRAI = 8'h0C;
    localparam logic [7:0] OP_SRLI = 8'h0D, OP_SLL = 8'h0E, OP_JAL = 8'h0F;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               MemRead, MemWrite, RegWrite, PCSrc;
    logic [1:0]         MemToReg, ALUSrc;
    logic [3:0]         ALUOp;
    logic [7:0]         Op;
    logic [IMEM_AW-1:0] pc;
    logic               stall, flush;
    logic [4:0]         dbg_raddr = '0;
    logic [XLEN-1:0]    dbg_rdata;

    int n_asserts = 0;
    int n_fail = 0;

    typedef struct {string tag; int kind; int idx; logic [31:0] val;} exp_t;
    typedef struct {int pc; logic stall; logic flush;} cyc_t;
    exp_t exp_q[$];
    cyc_t cyc_q[$];

    pipe_datapath_fwd #(
        .XLEN(XLEN), .NREGS(32), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW),
        .IMEM_FILE(""), .DMEM_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .Op(Op), .pc(pc), .stall(stall), .flush(flush),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in for the external control unit
    always_comb begin
        MemRead = 1'b0; MemWrite = 1'b0; MemToReg = 2'b01; RegWrite = 1'b0;
        PCSrc = 1'b0; ALUOp = 4'd0; ALUSrc = 2'b00;
        case (Op)
            OP_ADD:  RegWrite = 1'b1;
            OP_ADDI: begin RegWrite = 1'b1; ALUSrc = 2'b01; end
            OP_LW:   begin RegWrite = 1'b1; MemRead = 1'b1; MemToReg = 2'b00; ALUSrc = 2'b01; end
            OP_SW:   begin MemWrite = 1'b1; ALUSrc = 2'b01; end
            OP_J:    PCSrc = 1'b1;
            OP_SUB:  begin RegWrite = 1'b1; ALUOp = 4'd1; end
            OP_MUL:  begin RegWrite = 1'b1; ALUOp = 4'd2; end
            OP_XOR:  begin RegWrite = 1'b1; ALUOp = 4'd3; end
            OP_OR:   begin RegWrite = 1'b1; ALUOp = 4'd4; end
            OP_AND:  begin RegWrite = 1'b1; ALUOp = 4'd5; end
            OP_SLLI: begin RegWrite = 1'b1; ALUOp = 4'd6; ALUSrc = 2'b10; end
            OP_SRAI: begin RegWrite = 1'b1; ALUOp = 4'd7; ALUSrc = 2'b10; end
            OP_SRLI: begin RegWrite = 1'b1; ALUOp = 4'd8; ALUSrc = 2'b10; end
            OP_SLL:  begin RegWrite = 1'b1; ALUOp = 4'd6; end
            OP_JAL:  begin RegWrite = 1'b1; PCSrc = 1'b1; MemToReg = 2'b10; end
            default: ;
        endcase
    end

    function automatic logic [31:0] enc(logic [7:0] op, int rd, int rs1, int rs2, int imm);
        logic [31:0] w;
        w = {5'(rd), 5'(rs1), 5'(rs2), 9'(imm), op};
        return w;
    endfunction

    function automatic logic [31:0] enc_j(logic [7:0] op, int rd, int target);
        logic [31:0] w;
        w = {5'(rd), 19'(target), op};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 2**IMEM_AW; i++) dut.imem[i] = 8'h00;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.imem[addr]     = w[31:24];
        dut.imem[addr + 1] = w[23:16];
        dut.imem[addr + 2] = w[15:8];
        dut.imem[addr + 3] = w[7:0];
    endtask

    task automatic push_cyc(input int p, input logic s, input logic f);
        cyc_t c;
        c.pc = p; c.stall = s; c.flush = f;
        cyc_q.push_back(c);
    endtask

    task automatic push_seq(input int start, input int n);
        for (int i = 0; i < n; i++) push_cyc(start + 4 * i, 1'b0, 1'b0);
    endtask

    task automatic push_reg(input string tag, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = 0; e.idx = idx; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic push_mem(input string tag, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = 1; e.idx = idx; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_pc", 32'(pc), 32'd0);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_flush", 32'(flush), 32'd0);
            chk("rst_op", 32'(Op), 32'd0);
        end
        reset = 1'b0;
    endtask

    task automatic run(input string phase, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (cyc_q.size() > 0) begin
                cyc_t c;
                c = cyc_q.pop_front();
                chk($sformatf("%s_pc@%0d", phase, i + 1), 32'(pc), 32'(c.pc));
                chk($sformatf("%s_stall@%0d", phase, i + 1), 32'(stall), 32'(c.stall));
                chk($sformatf("%s_flush@%0d", phase, i + 1), 32'(flush), 32'(c.flush));
            end
        end
    endtask

    task automatic check_all();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.kind == 0) begin
                dbg_raddr = 5'(e.idx);
                #1;
                chk(e.tag, dbg_rdata, e.val);
            end else begin
                chk(e.tag, 32'(dut.dmem[e.idx]), e.val);
            end
        end
    endtask

    initial begin
        // Reset sequence and back-to-back EX/MEM forwarding
        clear_imem();
        put(8'h00, enc(OP_ADDI, 1, 0, 0, 5));
        put(8'h04, enc(OP_ADD, 2, 1, 1, 0));
        do_reset();
        push_seq(4, 14);
        push_reg("r1_addi", 1, 32'd5);
        push_reg("r2_fwd", 2, 32'd10);
        run("fwd", 14);
        check_all();

        // Store-data forwarding then a load-use interlock
        reset = 1'b1;
        clear_imem();
        put(8'h00, enc(OP_ADDI, 7, 0, 0, 8'h2A));
        put(8'h04, enc(OP_SW, 0, 0, 7, 0));
        put(8'h08, enc(OP_LW, 3, 0, 0, 0));
        put(8'h0C, enc(OP_ADD, 4, 3, 3, 0));
        do_reset();
        push_seq(4, 3);
        push_cyc(8'h10, 1'b1, 1'b0);
        push_cyc(8'h10, 1'b0, 1'b0);
        push_seq(8'h14, 9);
        push_mem("dmem3", 3, 32'h2A);
        push_reg("r3_lw", 3, 32'h2A);
        push_reg("r4_loaduse", 4, 32'h54);
        run("lduse", 14);
        check_all();

        // Jump flush: instruction after the jump must not retire
        reset = 1'b1;
        clear_imem();
        put(8'h00, enc(OP_ADDI, 8, 0, 0, 1));
        put(8'h04, enc(OP_ADDI, 9, 0, 0, 2));
        put(8'h08, enc_j(OP_J, 0, 8'h20));
        put(8'h0C, enc(OP_ADDI, 8, 0, 0, 8'h55));
        put(8'h20, enc(OP_ADDI, 11, 0, 0, 8'h44));
        do_reset();
        push_seq(4, 2);
        push_cyc(8'h0C, 1'b0, 1'b1);
        push_seq(8'h20, 11);
        push_reg("r8_squashed", 8, 32'd1);
        push_reg("r9", 9, 32'd2);
        push_reg("r11_target", 11, 32'h44);
        run("jump", 14);
        check_all();

        // Stores incl. wrap at the top of data memory, load back, rs2 load-use
        reset = 1'b1;
        clear_imem();
        put(8'h00, enc(OP_ADDI, 5, 0, 0, 8'h77));
        put(8'h04, enc(OP_SW, 0, 0, 5, 8));
        put(8'h08, enc(OP_ADDI, 12, 0, 0, 8'h7E));
        put(8'h0C, enc(OP_SW, 0, 12, 5, 0));
        put(8'h10, enc(OP_LW, 14, 0, 0, 8'h7E));
        put(8'h14, enc(OP_ADD, 28, 0, 14, 0));
        do_reset();
        push_seq(4, 5);
        push_cyc(8'h18, 1'b1, 1'b0);
        push_seq(8'h18, 8);
        push_mem("dmem8", 8, 32'h00);
        push_mem("dmem9", 9, 32'h00);
        push_mem("dmem10", 10, 32'h00);
        push_mem("dmem11", 11, 32'h77);
        push_mem("dmem7e", 8'h7E, 32'h00);
        push_mem("dmem7f", 8'h7F, 32'h00);
        push_mem("dmem0", 0, 32'h00);
        push_mem("dmem1", 1, 32'h77);
        push_reg("r14_wrapload", 14, 32'h77);
        push_reg("r28_rs2_loaduse", 28, 32'h77);
        run("store", 14);
        check_all();

        // R0 behaviour, ALU operations, JAL link value
        reset = 1'b1;
        clear_imem();
        put(8'h00, enc(OP_ADDI, 0, 0, 0, 9));
        put(8'h04, enc(OP_ADD, 6, 0, 0, 0));
        put(8'h08, enc(OP_ADDI, 15, 0, 0, -3));
        put(8'h0C, enc(OP_ADDI, 16, 0, 0, 6));
        put(8'h10, enc(OP_SUB, 17, 16, 15, 0));
        put(8'h14, enc(OP_MUL, 18, 15, 16, 0));
        put(8'h18, enc(OP_XOR, 19, 15, 16, 0));
        put(8'h1C, enc(OP_SRAI, 20, 15, 0, 1));
        put(8'h20, enc(OP_SRLI, 21, 15, 0, 4));
        put(8'h24, enc(OP_SLLI, 22, 16, 0, 29));
        put(8'h28, enc(OP_OR, 23, 15, 16, 0));
        put(8'h2C, enc(OP_AND, 24, 15, 16, 0));
        put(8'h30, enc(OP_ADDI, 25, 0, 0, 33));
        put(8'h34, enc(OP_SLL, 26, 16, 25, 0));
        put(8'h38, enc_j(OP_JAL, 29, 8'h48));
        put(8'h3C, enc(OP_ADDI, 29, 0, 0, 8'h99));
        do_reset();
        push_seq(4, 14);
        push_cyc(8'h3C, 1'b0, 1'b1);
        push_seq(8'h48, 9);
        push_reg("r0_zero", 0, 32'h0);
        push_reg("r6_r0sum", 6, 32'h0);
        push_reg("r15_negimm", 15, 32'hFFFF_FFFD);
        push_reg("r17_sub", 17, 32'd9);
        push_reg("r18_mul", 18, 32'hFFFF_FFEE);
        push_reg("r19_xor", 19, 32'hFFFF_FFFB);
        push_reg("r20_sra", 20, 32'hFFFF_FFFE);
        push_reg("r21_srl", 21, 32'h0FFF_FFFF);
        push_reg("r22_sll", 22, 32'hC000_0000);
        push_reg("r23_or", 23, 32'hFFFF_FFFF);
        push_reg("r24_and", 24, 32'h4);
        push_reg("r26_sllmod", 26, 32'hC);
        push_reg("r29_jal", 29, 32'h3C);
        run("alu", 24);
        check_all();

        // Reset while a load sits in MEM: the load must never retire
        reset = 1'b1;
        clear_imem();
        put(8'h00, enc(OP_ADDI, 27, 0, 0, 8'h11));
        put(8'h0C, enc(OP_LW, 27, 0, 0, 0));
        do_reset();
        push_seq(4, 6);
        run("midrst", 6);
        reset = 1'b1;
        clear_imem();
        do_reset();
        push_seq(4, 8);
        push_reg("r27_no_load", 27, 32'h11);
        run("postrst", 8);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
